// File: rtl/list_walk_sched_pkg.sv
// Shared types and sizing for the linked-list walk scheduler.
// LWS_HOP_LIMIT_EN adds a per-slot hop counter to the slot state.
package list_walk_sched_pkg;

   localparam int unsigned N        = 16;
   localparam int unsigned W        = $clog2(N);
   localparam int unsigned LAT      = 2;
   localparam int unsigned NREQ     = 4;
   localparam int unsigned MAX_HOPS = N;
   localparam int unsigned ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PH_W     = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int unsigned HOP_W    = $clog2(MAX_HOPS + 1);

   typedef logic [W-1:0]    ptr_t;
   typedef logic [ID_W-1:0] id_t;

`ifdef LWS_HOP_LIMIT_EN
   typedef logic [HOP_W-1:0] hop_t;
`endif

   typedef struct packed {
      logic busy;
      id_t  id;
`ifdef LWS_HOP_LIMIT_EN
      hop_t hops;
`endif
   } slot_t;

   // Requester index `off` positions after `base`, wrapping at NREQ.
   function automatic id_t rot_id(input id_t base, input int unsigned off);
      int unsigned sum;
      sum = (int'(base) + off) % NREQ;
      return ID_W'(sum);
   endfunction

endpackage

// File: rtl/list_walk_sched_if.sv
// Requester, pointer-memory and result signals of the list walk scheduler.
interface list_walk_sched_if;
   import list_walk_sched_pkg::*;

   logic [NREQ-1:0] req_vld;
   ptr_t [NREQ-1:0] req_ptr;
   logic [NREQ-1:0] req_rdy;
   logic            init_busy;
   logic            mem_re;
   ptr_t            mem_ra;
   ptr_t            mem_rd;
   logic            out_vld;
   ptr_t            out_ptr;
   id_t             out_id;
   logic            done_vld;
   id_t             done_id;
   logic            err_vld;

   modport master (
      output req_vld, req_ptr, init_busy, mem_rd,
      input  req_rdy, mem_re, mem_ra, out_vld, out_ptr, out_id,
             done_vld, done_id, err_vld
   );

   modport slave (
      input  req_vld, req_ptr, init_busy, mem_rd,
      output req_rdy, mem_re, mem_ra, out_vld, out_ptr, out_id,
             done_vld, done_id, err_vld
   );

endinterface

// File: rtl/list_walk_sched_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant among req & mask, priority moves past the winner.
module list_walk_sched_rr_arbiter
   import list_walk_sched_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] mask,
   output logic [NREQ-1:0] gnt,
   output id_t             win,
   output logic            any
);

   id_t rr_ptr;

   // First qualified requester at or after rr_ptr.
   always_comb begin
      gnt = '0;
      win = '0;
      any = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!any && req[rot_id(rr_ptr, i)] && mask[rot_id(rr_ptr, i)]) begin
            any                     = 1'b1;
            win                     = rot_id(rr_ptr, i);
            gnt[rot_id(rr_ptr, i)]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (any) begin
         rr_ptr <= rot_id(win, 1);
      end
   end

endmodule

// File: rtl/list_walk_sched.sv
// Interleaves up to LAT linked-list walks through one pointer memory with read latency LAT.
// Optional LWS_HOP_LIMIT_EN aborts walks that exceed MAX_HOPS issued pointers.
module list_walk_sched
   import list_walk_sched_pkg::*;
(
   input logic              clk,
   input logic              rst,
   list_walk_sched_if.slave bus
);

   logic [PH_W-1:0] phase;
   slot_t           slots     [LAT];
   slot_t           slots_nxt [LAT];
   slot_t           cur;

   logic            fin;
   logic            abort;
   logic            cont;
   logic            done_now;
   logic            avail;
   logic [NREQ-1:0] mask;
   logic [NREQ-1:0] gnt;
   id_t             win;
   logic            any;
   ptr_t            win_ptr;
   logic            issue_new;
   logic            null_gnt;
   logic            re_c;
   ptr_t            ra_c;
   id_t             issue_id;

   logic            out_vld_q;
   ptr_t            out_ptr_q;
   id_t             out_id_q;
   logic            done_vld_q;
   id_t             done_id_q;

   // Phase selects the slot whose read data is returning this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= '0;
      end else if (phase == PH_W'(LAT - 1)) begin
         phase <= '0;
      end else begin
         phase <= phase + 1'b1;
      end
   end

   // Decode what the serviced slot does with the returning pointer.
   always_comb begin
      cur   = slots[phase];
      fin   = 1'b0;
      abort = 1'b0;
      cont  = 1'b0;
      if (cur.busy && !bus.init_busy) begin
         if (bus.mem_rd == '0) begin
            fin = 1'b1;
         end
`ifdef LWS_HOP_LIMIT_EN
         else if (cur.hops >= HOP_W'(MAX_HOPS)) begin
            abort = 1'b1;
         end
`endif
         else begin
            cont = 1'b1;
         end
      end
   end

   assign done_now = fin | abort;
   assign avail    = !rst && !bus.init_busy && (!cur.busy || done_now);

   // A slot that is already reporting done cannot also report a null-start done.
   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         mask[i] = avail && !(done_now && (bus.req_ptr[i] == '0));
      end
   end

   list_walk_sched_rr_arbiter u_rr_arbiter (
      .clk  (clk),
      .rst  (rst),
      .req  (bus.req_vld),
      .mask (mask),
      .gnt  (gnt),
      .win  (win),
      .any  (any)
   );

   // Memory read issue: continue the current walk or start the granted one.
   always_comb begin
      win_ptr   = bus.req_ptr[win];
      issue_new = any && (win_ptr != '0);
      null_gnt  = any && (win_ptr == '0);
      re_c      = cont || issue_new;
      ra_c      = '0;
      issue_id  = '0;
      if (cont) begin
         ra_c     = bus.mem_rd;
         issue_id = cur.id;
      end else if (issue_new) begin
         ra_c     = win_ptr;
         issue_id = win;
      end
   end

   // Slot next-state.
   always_comb begin
      slots_nxt = slots;
      if (bus.init_busy) begin
         for (int unsigned s = 0; s < LAT; s++) begin
            slots_nxt[s] = '0;
         end
      end else begin
`ifdef LWS_HOP_LIMIT_EN
         if (cont) begin
            slots_nxt[phase].hops = cur.hops + 1'b1;
         end
`endif
         if (done_now) begin
            slots_nxt[phase].busy = 1'b0;
         end
         if (issue_new) begin
            slots_nxt[phase].busy = 1'b1;
            slots_nxt[phase].id   = win;
`ifdef LWS_HOP_LIMIT_EN
            slots_nxt[phase].hops = HOP_W'(1);
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned s = 0; s < LAT; s++) begin
            slots[s] <= '0;
         end
      end else begin
         slots <= slots_nxt;
      end
   end

   // Visit and completion reports, one cycle after the decision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         out_ptr_q  <= '0;
         out_id_q   <= '0;
         done_vld_q <= 1'b0;
         done_id_q  <= '0;
      end else begin
         out_vld_q  <= re_c;
         out_ptr_q  <= ra_c;
         out_id_q   <= issue_id;
         done_vld_q <= done_now || null_gnt;
         if (done_now) begin
            done_id_q <= cur.id;
         end else if (null_gnt) begin
            done_id_q <= win;
         end else begin
            done_id_q <= '0;
         end
      end
   end

`ifdef LWS_HOP_LIMIT_EN
   logic err_vld_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_vld_q <= 1'b0;
      end else begin
         err_vld_q <= abort;
      end
   end

   assign bus.err_vld = err_vld_q;
`else
   assign bus.err_vld = 1'b0;
`endif

   assign bus.req_rdy  = gnt;
   assign bus.mem_re   = re_c;
   assign bus.mem_ra   = ra_c;
   assign bus.out_vld  = out_vld_q;
   assign bus.out_ptr  = out_ptr_q;
   assign bus.out_id   = out_id_q;
   assign bus.done_vld = done_vld_q;
   assign bus.done_id  = done_id_q;

endmodule

// File: tb/tb_list_walk_sched.sv
// Directed bench for list_walk_sched over the list 7-15-8, 6, 2-4, 1-5-3-10 with a LAT=2 memory.
module tb_list_walk_sched;
   import list_walk_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   list_walk_sched_if bus ();

   list_walk_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Pointer memory with two-cycle read latency.
   ptr_t mem [N];
   ptr_t p1 = '0;
   ptr_t p2 = '0;
   always @(posedge clk) begin
      p1 <= bus.mem_re ? mem[bus.mem_ra] : '0;
      p2 <= p1;
   end
   assign bus.mem_rd = p2;

   int checks = 0;
   int errors = 0;
   int re_exp = -1;
   bit drop   = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One cycle: sample at negedge, then advance past the next rising edge.
   task automatic cyc(input string tag, input logic [NREQ-1:0] rdy, input logic ov,
                      input ptr_t op, input id_t oi, input logic dv, input id_t di);
      logic [NREQ-1:0] acc;
      @(negedge clk);
      acc = bus.req_rdy;
      chk({tag, ".rdy"}, 32'(bus.req_rdy), 32'(rdy));
      chk({tag, ".out_vld"}, 32'(bus.out_vld), 32'(ov));
      if (ov) begin
         chk({tag, ".out_ptr"}, 32'(bus.out_ptr), 32'(op));
         chk({tag, ".out_id"}, 32'(bus.out_id), 32'(oi));
      end
      chk({tag, ".done_vld"}, 32'(bus.done_vld), 32'(dv));
      if (dv) chk({tag, ".done_id"}, 32'(bus.done_id), 32'(di));
      chk({tag, ".err_vld"}, 32'(bus.err_vld), 32'(0));
      if (re_exp >= 0) begin
         chk({tag, ".mem_re"}, 32'(bus.mem_re), 32'(re_exp));
         re_exp = -1;
      end
      @(posedge clk);
      #1;
      if (drop) bus.req_vld = bus.req_vld & ~acc;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.init_busy = 1'b0;
      bus.req_vld   = '1;
      for (int i = 0; i < NREQ; i++) bus.req_ptr[i] = ptr_t'(7);
      @(negedge clk);
      chk("rst.rdy", 32'(bus.req_rdy), 32'(0));
      chk("rst.mem_re", 32'(bus.mem_re), 32'(0));
      chk("rst.out", 32'({bus.out_vld, bus.out_ptr, bus.out_id}), 32'(0));
      chk("rst.done", 32'({bus.done_vld, bus.done_id}), 32'(0));
      chk("rst.err_vld", 32'(bus.err_vld), 32'(0));
      bus.req_vld = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input ptr_t p);
      bus.req_vld[i] = 1'b1;
      bus.req_ptr[i] = p;
   endtask

   initial begin
      for (int i = 0; i < N; i++) mem[i] = '0;
      mem[7] = 15; mem[15] = 8;  mem[8] = 0;
      mem[6] = 0;
      mem[2] = 4;  mem[4]  = 0;
      mem[1] = 5;  mem[5]  = 3;  mem[3] = 10; mem[10] = 0;
      bus.init_busy = 1'b0;
      bus.req_vld   = '0;
      bus.req_ptr   = '0;

      // Single walk 7-15-8
      do_reset();
      set_req(0, 7);
      re_exp = 1;
      cyc("t1c0", 4'b0001, 0, 0,  0, 0, 0);
      cyc("t1c1", 4'b0000, 1, 7,  0, 0, 0);
      cyc("t1c2", 4'b0000, 0, 0,  0, 0, 0);
      cyc("t1c3", 4'b0000, 1, 15, 0, 0, 0);
      cyc("t1c4", 4'b0000, 0, 0,  0, 0, 0);
      cyc("t1c5", 4'b0000, 1, 8,  0, 0, 0);
      cyc("t1c6", 4'b0000, 0, 0,  0, 0, 0);
      cyc("t1c7", 4'b0000, 0, 0,  0, 1, 0);

      // Two interleaved walks
      do_reset();
      set_req(0, 7);
      set_req(1, 6);
      cyc("t2c0", 4'b0001, 0, 0,  0, 0, 0);
      cyc("t2c1", 4'b0010, 1, 7,  0, 0, 0);
      cyc("t2c2", 4'b0000, 1, 6,  1, 0, 0);
      cyc("t2c3", 4'b0000, 1, 15, 0, 0, 0);
      cyc("t2c4", 4'b0000, 0, 0,  0, 1, 1);
      cyc("t2c5", 4'b0000, 1, 8,  0, 0, 0);
      cyc("t2c6", 4'b0000, 0, 0,  0, 0, 0);
      cyc("t2c7", 4'b0000, 0, 0,  0, 1, 0);

      // Fairness with all requesters held valid
      do_reset();
      drop = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 6);
      cyc("t3c0", 4'b0001, 0, 0, 0, 0, 0);
      cyc("t3c1", 4'b0010, 1, 6, 0, 0, 0);
      cyc("t3c2", 4'b0100, 1, 6, 1, 0, 0);
      cyc("t3c3", 4'b1000, 1, 6, 2, 1, 0);
      cyc("t3c4", 4'b0001, 1, 6, 3, 1, 1);
      bus.req_vld = '0;
      drop = 1'b1;
      cyc("t3c5", 4'b0000, 1, 6, 0, 1, 2);
      cyc("t3c6", 4'b0000, 0, 0, 0, 1, 3);
      cyc("t3c7", 4'b0000, 0, 0, 0, 1, 0);

      // Null start and slot reuse at finish
      do_reset();
      set_req(0, 6);
      set_req(2, 0);
      set_req(3, 2);
      cyc("t4c0", 4'b0001, 0, 0, 0, 0, 0);
      re_exp = 0;
      cyc("t4c1", 4'b0100, 1, 6, 0, 0, 0);
      cyc("t4c2", 4'b1000, 0, 0, 0, 1, 2);
      cyc("t4c3", 4'b0000, 1, 2, 3, 1, 0);
      cyc("t4c4", 4'b0000, 0, 0, 0, 0, 0);
      cyc("t4c5", 4'b0000, 1, 4, 3, 0, 0);
      cyc("t4c6", 4'b0000, 0, 0, 0, 0, 0);
      cyc("t4c7", 4'b0000, 0, 0, 0, 1, 3);

      // Flush during the walk from 1, then a fresh walk from 1
      do_reset();
      set_req(1, 1);
      cyc("t5c0", 4'b0010, 0, 0, 0, 0, 0);
      cyc("t5c1", 4'b0000, 1, 1, 1, 0, 0);
      bus.init_busy = 1'b1;
      set_req(3, 1);
      re_exp = 0;
      cyc("t5c2", 4'b0000, 0, 0, 0, 0, 0);
      cyc("t5c3", 4'b0000, 0, 0, 0, 0, 0);
      bus.init_busy = 1'b0;
      cyc("t5c4",  4'b1000, 0, 0,  0, 0, 0);
      cyc("t5c5",  4'b0000, 1, 1,  3, 0, 0);
      cyc("t5c6",  4'b0000, 0, 0,  0, 0, 0);
      cyc("t5c7",  4'b0000, 1, 5,  3, 0, 0);
      cyc("t5c8",  4'b0000, 0, 0,  0, 0, 0);
      cyc("t5c9",  4'b0000, 1, 3,  3, 0, 0);
      cyc("t5c10", 4'b0000, 0, 0,  0, 0, 0);
      cyc("t5c11", 4'b0000, 1, 10, 3, 0, 0);
      cyc("t5c12", 4'b0000, 0, 0,  0, 0, 0);
      cyc("t5c13", 4'b0000, 0, 0,  0, 1, 3);

      // Reset in the middle of a walk discards it silently
      do_reset();
      set_req(0, 7);
      cyc("t6c0", 4'b0001, 0, 0, 0, 0, 0);
      cyc("t6c1", 4'b0000, 1, 7, 0, 0, 0);
      do_reset();
      for (int c = 0; c < 6; c++) cyc($sformatf("t6q%0d", c), 4'b0000, 0, 0, 0, 0, 0);

`ifdef LWS_HOP_LIMIT_EN
      // Self-loop stopped by the hop limit
      begin
         int   nvis    = 0;
         int   err_cyc = -1;
         logic dv_err  = 1'b0;
         id_t  did_err = '0;
         do_reset();
         mem[3] = 3;
         set_req(0, 3);
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_vld && bus.out_ptr == ptr_t'(3)) nvis++;
            if (bus.err_vld && err_cyc < 0) begin
               err_cyc = c;
               dv_err  = bus.done_vld;
               did_err = bus.done_id;
            end
            @(posedge clk);
            #1;
            bus.req_vld = '0;
         end
         chk("t7.visits", 32'(nvis), 32'(16));
         chk("t7.err_cycle", 32'(err_cyc), 32'(33));
         chk("t7.done_with_err", 32'(dv_err), 32'(1));
         chk("t7.done_id", 32'(did_err), 32'(0));
         mem[3] = 10;
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/list_walk_sched.md
# list_walk_sched

Round-robin scheduler that lets several requesters share one linked-list pointer memory with read latency LAT. Each requester hands in a start pointer. The block walks the list (next = mem[cur], 0 terminates) and interleaves up to LAT walks in the read pipeline, so the memory can issue one read per cycle with no bubbles. It sits between the start-pointer sources and the pointer memory, and it owns the memory read port.

## Interface
- N, 16, number of list nodes; pointer 0 is null.
- W, $clog2(N), pointer width.
- LAT, 2, memory read latency in cycles; also the number of walk slots.
- NREQ, 4, number of requesters.
- MAX_HOPS, N, hop limit, used only with the hop-limit macro.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_vld  in  NREQ  per-requester start valid.
- req_ptr  in  NREQ×W  per-requester start pointer.
- req_rdy  out  NREQ  per-requester accept, one-hot or zero.
- init_busy  in  1  memory being (re)written; blocks grants and flushes slots.
- mem_re  out  1  read enable.
- mem_ra  out  W  read address.
- mem_rd  in  W  read data, valid LAT cycles after mem_re.
- out_vld  out  1  a pointer of a walk was visited.
- out_ptr  out  W  visited pointer.
- out_id  out  $clog2(NREQ)  owning requester.
- done_vld  out  1  a walk finished.
- done_id  out  $clog2(NREQ)  requester whose walk finished.
- err_vld  out  1  walk aborted on hop limit; constant 0 without the macro.

## Operation
- phase counter 0..LAT-1 increments every cycle and wraps. Slot s is serviced only when phase==s.
- Each slot holds: busy, id, and a hop count (hop count only with the macro).
- Serviced busy slot: mem_rd is its next pointer.
  - If nonzero, issue mem_re with mem_ra = mem_rd.
  - If zero, free the slot and pulse done.
- Serviced free slot, including one freed in the same cycle: grant one requester.
  - Scan round-robin from rr_ptr; grant the first with req_vld=1 and req_rdy=1.
  - rr_ptr becomes winner+1, modulo NREQ.
  - Issue mem_ra = req_ptr and mark the slot busy with id = winner.
- Grant of req_ptr==0: handshake completes, nothing is issued, the slot stays free, and done pulses for that id.
- req_rdy is combinational from req_vld, slot state, rr_ptr, phase and init_busy. req_ptr must be stable while req_vld=1 and req_rdy=0.
- init_busy=1: no grants, mem_re=0, all slots cleared at the next edge with no done pulses. Phase keeps running.
- Finish and grant in the same slot and cycle are both performed: done for the old id, issue for the new one.

## Timing
- Issue in cycle t: out_vld, out_ptr, out_id registered at t+1. Next pointer is consumed at t+LAT.
- done_vld and done_id are registered one cycle after the 0 is returned, or one cycle after a null grant.
- A walk of k nodes granted at t finishes with done at t+k·LAT+1.
- Throughput is one read per cycle when all LAT slots are busy.
- Reset values: all outputs 0, slots free, phase 0, rr_ptr 0.
- rst mid-walk discards every walk with no done pulses.

## Configuration
- LWS_HOP_LIMIT_EN defined: each slot counts issued pointers.
  - An issue that would exceed MAX_HOPS is suppressed and the slot is freed.
  - err_vld and done_vld with the id pulse one cycle later.
  - This guards against cyclic lists.
- LWS_HOP_LIMIT_EN undefined: no counters; err_vld tied 0; a cyclic list occupies its slot until reset or init_busy.

## Structure
- Shared package: W, the Pointer typedef, the requester-id typedef, and the slot-state struct.
- Sub-module rr_arbiter (NREQ-wide request/mask in, one-hot grant out, rotating priority).

## Test plan
List used throughout: 7→15→8→0, 6→0, 2→4→0, 1→5→3→10→0, LAT=2.
- Single walk: req0 ptr 7 at cycle 0 → out_ptr 7, 15, 8 (id 0) at cycles 1, 3, 5; done id 0 at cycle 7.
- Interleave: req0=7 and req1=6 at cycle 0 → grants at cycles 0 and 1; out_ptr 7, 6, 15, 8 at cycles 1, 2, 3, 5; done id 1 at cycle 4, id 0 at cycle 7.
- Fairness: requesters 0..3 held valid with ptr 6 → grants in order 0, 1, 2, 3, 0 with no requester granted twice before the others.
- Null start and slot reuse: req2 ptr 0 → done id 2 the next cycle, no out_vld; a pending req ptr 2 is granted in the slot freed by the walk for 6 in the same cycle it finishes.
- Flush: init_busy pulsed during the walk from 1 → no further out_vld or done for it; a fresh req ptr 1 afterwards yields 1, 5, 3, 10 and done.
- Macro on, self-loop 3→3, MAX_HOPS=16 → exactly 16 out_vld with ptr 3, then err_vld and done_vld together.
